// File: rtl/alu_issue_ctrl.sv
// Issue stage feeding the 4-bit combinational ALU: command FIFO,
// registered ALU operands, and a held valid/ready response.
module alu_issue_ctrl #(
    parameter int DATA_W     = 4,
    parameter int OP_W       = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [DATA_W-1:0]             cmd_a,
    input  logic [DATA_W-1:0]             cmd_b,
    input  logic [OP_W-1:0]               cmd_op,
    output logic [DATA_W-1:0]             alu_a,
    output logic [DATA_W-1:0]             alu_b,
    output logic [OP_W-1:0]               alu_operation,
    input  logic [DATA_W-1:0]             alu_result,
    input  logic                          alu_carry,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_W-1:0]             rsp_result,
    output logic                          rsp_carry,
    output logic [OP_W-1:0]               rsp_op,
    output logic                          rsp_illegal,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem_a  [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_b  [FIFO_DEPTH];
    logic [OP_W-1:0]   mem_op [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic capture;
    logic rsp_done;

    assign full      = (fifo_count == CW'(FIFO_DEPTH));
    assign empty     = (fifo_count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!empty) state_nxt = ISSUE;
            ISSUE:   state_nxt = HOLD;
            HOLD: begin
                if (rsp_ready) state_nxt = empty ? IDLE : ISSUE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A pop in HOLD only happens on the handshake edge, so a full FIFO
    // cannot also push that cycle (cmd_ready looks at full alone).
    always_comb begin
        pop      = 1'b0;
        capture  = 1'b0;
        rsp_done = 1'b0;
        unique case (state)
            IDLE:    pop = !empty;
            ISSUE:   capture = 1'b1;
            HOLD: begin
                rsp_done = rsp_ready;
                pop      = rsp_ready && !empty;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]  <= cmd_a;
            mem_b[wr_ptr]  <= cmd_b;
            mem_op[wr_ptr] <= cmd_op;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) fifo_count <= fifo_count + CW'(1);
            else if (pop && !push) fifo_count <= fifo_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a         <= '0;
            alu_b         <= '0;
            alu_operation <= '0;
            rsp_op        <= '0;
        end else if (pop) begin
            alu_a         <= mem_a[rd_ptr];
            alu_b         <= mem_b[rd_ptr];
            alu_operation <= mem_op[rd_ptr];
            rsp_op        <= mem_op[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_carry   <= 1'b0;
            rsp_illegal <= 1'b0;
        end else if (capture) begin
            rsp_valid   <= 1'b1;
            rsp_result  <= alu_result;
            rsp_carry   <= alu_carry;
            rsp_illegal <= (alu_operation > OP_W'(4));
        end else if (rsp_done) begin
            rsp_valid   <= 1'b0;
        end
    end

endmodule
